// File: rtl/branch_resolve_if.sv
// Execute-to-resolver bus: branch inputs, flush/redirect outputs, the predictor
// update port and statistics.
//
// Handshake: the predictor update port is valid/ready. An entry transfers on a
// rising clk edge where upd_valid & upd_ready are both high. While upd_valid is
// high, upd_pc/upd_taken stay stable until that transfer happens. upd_valid
// never depends on upd_ready. On the execute side, stall is the back-pressure:
// while it is high, execute holds every ex_* input unchanged.
interface branch_resolve_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  ex_valid;
    logic                  ex_isBranch;
    logic                  ex_branchTaken;
    logic                  ex_predTaken;
    logic [ADDR_WIDTH-1:0] ex_pc;
    logic [ADDR_WIDTH-1:0] ex_target;
    logic                  stall;
    logic                  flush;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  upd_valid;
    logic                  upd_ready;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic                  upd_taken;
    logic [CNT_WIDTH-1:0]  br_count;
    logic [CNT_WIDTH-1:0]  mispredict_count;
    logic                  dbg_state;

    modport master (
        output ex_valid, ex_isBranch, ex_branchTaken, ex_predTaken, ex_pc, ex_target,
        output upd_ready,
        input  stall, flush, redirect_valid, redirect_pc,
        input  upd_valid, upd_pc, upd_taken,
        input  br_count, mispredict_count, dbg_state
    );

    modport slave (
        input  ex_valid, ex_isBranch, ex_branchTaken, ex_predTaken, ex_pc, ex_target,
        input  upd_ready,
        output stall, flush, redirect_valid, redirect_pc,
        output upd_valid, upd_pc, upd_taken,
        output br_count, mispredict_count, dbg_state
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver. It checks each branch against the fetch-time
// prediction, raises flush and redirect on a mispredict, and queues predictor
// training updates. It also keeps branch and mispredict statistics.
module branch_resolve_unit #(
    parameter int ADDR_WIDTH   = 32,
    parameter int UPD_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input logic             clk,
    input logic             rst,
    branch_resolve_if.slave bus
);
    localparam int PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(UPD_DEPTH);
    localparam logic [FC_W-1:0] FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [FC_W-1:0]       fc_q, fc_d;
    logic                  redir_valid_q, redir_valid_d;
    logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;

    logic [ADDR_WIDTH-1:0] mem_pc    [UPD_DEPTH];
    logic                  mem_taken [UPD_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q;

    logic [CNT_WIDTH-1:0]  br_cnt_q, mis_cnt_q;

    logic                  stall;
    logic                  resolve;
    logic                  mispredict;
    logic                  push;
    logic                  pop;
    logic                  fifo_nonempty;
    logic [ADDR_WIDTH-1:0] next_pc;

    // stall depends only on registered occupancy, so upd_ready cannot combinationally reach execute.
    assign stall         = (count_q == FIFO_FULL);
    assign fifo_nonempty = (count_q != '0);
    assign resolve       = bus.ex_valid & bus.ex_isBranch & ~stall & (state_q == S_IDLE);
    assign mispredict    = resolve & (bus.ex_predTaken != bus.ex_branchTaken);
    assign next_pc       = bus.ex_branchTaken ? bus.ex_target
                                              : bus.ex_pc + ADDR_WIDTH'(4);
    assign push          = resolve;
    assign pop           = fifo_nonempty & bus.upd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            fc_q          <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            fc_q          <= fc_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    // The flush counter loads FLUSH_CYCLES-1 on entry. FLUSH exits on the edge after it reads zero.
    always_comb begin
        state_d       = state_q;
        fc_d          = fc_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        case (state_q)
            S_IDLE: begin
                if (mispredict) begin
                    state_d       = S_FLUSH;
                    fc_d          = FC_LOAD;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = next_pc;
                end
            end
            S_FLUSH: begin
                if (fc_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    fc_d = fc_q - FC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                fc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]    <= bus.ex_pc;
            mem_taken[wr_ptr_q] <= bus.ex_branchTaken;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (resolve && (br_cnt_q != '1))    br_cnt_q  <= br_cnt_q + CNT_WIDTH'(1);
            if (mispredict && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.stall            = stall;
    assign bus.flush            = (state_q == S_FLUSH);
    assign bus.redirect_valid   = redir_valid_q;
    assign bus.redirect_pc      = redir_pc_q;
    assign bus.upd_valid        = fifo_nonempty;
    assign bus.upd_pc           = fifo_nonempty ? mem_pc[rd_ptr_q] : '0;
    assign bus.upd_taken        = fifo_nonempty ? mem_taken[rd_ptr_q] : 1'b0;
    assign bus.br_count         = br_cnt_q;
    assign bus.mispredict_count = mis_cnt_q;
    assign bus.dbg_state        = state_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios plus randomized
// traffic, checked against an occupancy/flush-window model of the resolver.
module tb_branch_resolve_unit;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int FC    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  branch_resolve_unit #(
    .ADDR_WIDTH(AW), .UPD_DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [AW:0]   exp_q[$];
  logic [AW-1:0] redir_q[$];

  int occ        = 0;
  int flush_left = 0;
  int br_m       = 0;
  int mis_m      = 0;
  bit redir_exp  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    occ = 0; flush_left = 0; br_m = 0; mis_m = 0; redir_exp = 0;
    exp_q.delete();
    redir_q.delete();
  endtask

  // Call at posedge+1: drives one cycle, checks at negedge, updates model at posedge.
  task automatic cycle(input bit v, input bit br, input bit act, input bit pred,
                       input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                       input bit rdy, output bit accepted);
    bit mis;
    bit pop_ok;
    bus.ex_valid = v; bus.ex_isBranch = br; bus.ex_branchTaken = act;
    bus.ex_predTaken = pred; bus.ex_pc = pc; bus.ex_target = tgt; bus.upd_ready = rdy;
    @(negedge clk);
    chk("stall", bus.stall, occ == DEPTH);
    chk("flush", bus.flush, flush_left > 0);
    chk("upd_valid", bus.upd_valid, occ != 0);
    chk("redirect_valid", bus.redirect_valid, redir_exp);
    chk("br_count", bus.br_count, br_m);
    chk("mispredict_count", bus.mispredict_count, mis_m);
    accepted = v && br && (occ < DEPTH) && (flush_left == 0);
    mis = accepted && (act != pred);
    if (accepted) exp_q.push_back({pc, act});
    if (mis) redir_q.push_back(act ? tgt : pc + 32'd4);
    pop_ok = (occ > 0) && rdy;
    @(posedge clk);
    if (pop_ok) occ--;
    if (accepted) occ++;
    if (mis) flush_left = FC;
    else if (flush_left > 0) flush_left--;
    redir_exp = mis;
    if (accepted && br_m < CMAX) br_m++;
    if (mis && mis_m < CMAX) mis_m++;
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] pc, input bit act, input bit pred,
                       input logic [AW-1:0] tgt, input bit rdy);
    bit acc = 0;
    int budget = 40;
    while (!acc && budget > 0) begin
      cycle(1, 1, act, pred, pc, tgt, rdy, acc);
      budget--;
    end
    if (!acc) chk("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, '0, rdy, acc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transfer.
  initial begin
    logic [AW:0]   e;
    logic [AW-1:0] r;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.upd_valid === 1'b1 && bus.upd_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("upd_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("upd_pc", bus.upd_pc, e[AW:1]);
          chk("upd_taken", bus.upd_taken, e[0]);
        end
      end
      if (rst === 1'b1 && bus.redirect_valid === 1'b1) begin
        if (redir_q.size() == 0) chk("redirect_unexpected", 1, 0);
        else begin
          r = redir_q.pop_front();
          chk("redirect_pc", bus.redirect_pc, r);
        end
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_flush"}, bus.flush, 0);
    chk({tag, "_upd_valid"}, bus.upd_valid, 0);
    chk({tag, "_upd_pc"}, bus.upd_pc, 0);
    chk({tag, "_redirect_valid"}, bus.redirect_valid, 0);
    chk({tag, "_redirect_pc"}, bus.redirect_pc, 0);
    chk({tag, "_stall"}, bus.stall, 0);
    chk({tag, "_br_count"}, bus.br_count, 0);
    chk({tag, "_mis_count"}, bus.mispredict_count, 0);
  endtask

  initial begin
    bit acc;
    logic [AW-1:0] pc, tgt;
    rst = 1'b0;
    bus.ex_valid = 0; bus.ex_isBranch = 0; bus.ex_branchTaken = 0; bus.ex_predTaken = 0;
    bus.ex_pc = '0; bus.ex_target = '0; bus.upd_ready = 0;
    model_clear();
    #1;
    check_cleared("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // 1: correctly predicted taken branch
    issue(32'h100, 1, 1, 32'h180, 0);
    chk("t1_upd_pc", bus.upd_pc, 32'h100);
    chk("t1_upd_taken", bus.upd_taken, 1);
    idle(1, 1);

    // 2: predicted not-taken, actually taken
    issue(32'h200, 1, 0, 32'h240, 1);
    idle(4, 1);
    chk("t2_redirect_hold", bus.redirect_pc, 32'h240);

    // 3: predicted taken, actually not taken; a wrong-path branch arrives during flush
    issue(32'h300, 0, 1, 32'h380, 1);
    cycle(1, 1, 1, 1, 32'h308, 32'h400, 1, acc);
    chk("t3_flush_branch_dropped", acc, 0);
    idle(3, 1);

    // 4: fill the FIFO with upd_ready low, hold a fifth branch, then drain
    for (int i = 1; i <= 4; i++) issue(32'(i * 16), 1, 1, 32'h1000, 0);
    chk("t4_stall_full", bus.stall, 1);
    cycle(1, 1, 1, 1, 32'h50, 32'h1000, 0, acc);
    cycle(1, 1, 1, 1, 32'h50, 32'h1000, 0, acc);
    issue(32'h50, 1, 1, 32'h1000, 1);
    idle(6, 1);

    // 5: two entries queued, then push and pop on the same edge
    issue(32'h500, 0, 0, 32'h0, 0);
    issue(32'h510, 1, 1, 32'h600, 0);
    cycle(1, 1, 0, 0, 32'h520, 32'h0, 1, acc);
    chk("t5_push_accepted", acc, 1);
    chk("t5_head_advanced", bus.upd_pc, 32'h510);
    chk("t5_count_two_not_full", bus.stall, 0);
    idle(4, 1);

    // 6: reset during the first flush cycle with three queued entries
    issue(32'hA00, 1, 1, 32'hB00, 0);
    issue(32'hA10, 0, 0, 32'hB00, 0);
    issue(32'hA20, 1, 0, 32'hC00, 0);
    chk("t6_in_flush", bus.flush, 1);
    #3 rst = 1'b0;
    #1;
    check_cleared("t6_async_reset");
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    issue(32'h100, 1, 1, 32'h180, 0);
    chk("t6_after_upd_pc", bus.upd_pc, 32'h100);
    idle(2, 1);

    // Random traffic, including PC+4 wrap and counter saturation
    for (int i = 0; i < 400; i++) begin
      pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      tgt = $urandom() & 32'hFFFF_FFFC;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            pc, tgt, $urandom_range(0, 2) != 0, acc);
    end
    idle(10, 1);
    chk("drain_upd_queue_empty", exp_q.size(), 0);
    chk("drain_redirect_queue_empty", redir_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
